// File: rtl/dftpulse_capture_if.sv
// Handshake/result bundle between the DFT pulse capture block and the
// scan/test controller. The controller side drives pulse and control
// strobes; the capture block returns the measurement and status.
interface dftpulse_capture_if #(
  parameter int CNT_W = 8,
  parameter int NUM_W = 8
);
  logic             pulse;
  logic             arm;
  logic             clear;
  logic             rd_ack;
  logic [CNT_W-1:0] width;
  logic [NUM_W-1:0] count;
  logic             res_valid;
  logic             ovf;
  logic             drop;
  logic             busy;

  modport master (
    output pulse, arm, clear, rd_ack,
    input  width, count, res_valid, ovf, drop, busy
  );

  modport slave (
    input  pulse, arm, clear, rd_ack,
    output width, count, res_valid, ovf, drop, busy
  );
endinterface

// File: rtl/dftpulse_capture.sv
// Pulse width capture: synchronizes the generator's pulse, measures each
// armed pulse's high time in clk cycles, counts completed pulses and hands
// each result to the test controller through res_valid/rd_ack.
module dftpulse_capture #(
  parameter int CNT_W       = 8,
  parameter int NUM_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic CELV,
  input  logic CELG,
  input  logic SUB,
  dftpulse_capture_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARMED, HIGH, REPORT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [NUM_W-1:0] NUM_MAX = {NUM_W{1'b1}};

  // Supply/ground/substrate pins are physical only.
  logic unused_supply;
  assign unused_supply = &{1'b0, CELV, CELG, SUB};

  logic [SYNC_STAGES-1:0] sync;
  logic                   ps, ps_d;
  logic                   rise, fall;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] width_q;
  logic [NUM_W-1:0] count_q;
  logic             res_valid_q, ovf_q, drop_q, busy_q;

  // Bring the asynchronous pulse into clk and keep one cycle of history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      ps_d <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], bus.pulse};
      ps_d <= ps;
    end
  end

  assign ps   = sync[SYNC_STAGES-1];
  assign rise = ps & ~ps_d;
  assign fall = ~ps & ps_d;

  // Capture FSM; clear overrides every transition but keeps the last width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      width_q     <= '0;
      count_q     <= '0;
      res_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      drop_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else if (bus.clear) begin
      state       <= IDLE;
      count_q     <= '0;
      res_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      drop_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.arm) begin
            state  <= ARMED;
            busy_q <= 1'b1;
          end
        end
        ARMED: begin
          // Only a fresh rise starts a measurement, so a pulse already high
          // when we get here is skipped entirely.
          if (rise) begin
            state <= HIGH;
            cnt   <= CNT_W'(1);
          end
        end
        HIGH: begin
          if (ps) begin
            if (cnt == CNT_MAX) ovf_q <= 1'b1;
            else                cnt   <= cnt + 1'b1;
          end else if (fall) begin
            state       <= REPORT;
            width_q     <= cnt;
            res_valid_q <= 1'b1;
            if (count_q != NUM_MAX) count_q <= count_q + 1'b1;
          end
        end
        REPORT: begin
          if (rise) drop_q <= 1'b1;
          if (bus.rd_ack) begin
            res_valid_q <= 1'b0;
            state       <= ARMED;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.width     = width_q;
  assign bus.count     = count_q;
  assign bus.res_valid = res_valid_q;
  assign bus.ovf       = ovf_q;
  assign bus.drop      = drop_q;
  assign bus.busy      = busy_q;

endmodule

// File: doc/dftpulse_capture.md
# dftpulse_capture

Receive-side companion to the DFT pulse generator. Samples the generator's `pulse` output in the `clk` domain and measures each pulse's high width in clock cycles. Keeps a saturating pulse count and presents each result to the scan/test controller through a valid/ack handshake. Lives in the same feedback-loop DFT hierarchy, on the same supply rails.

## Interface
Parameters:
- `CNT_W`, 8: width of the pulse-width measurement counter.
- `NUM_W`, 8: width of the pulse counter.
- `SYNC_STAGES`, 2: synchronizer depth for `pulse`; legal values are 2 or 3.

Ports:
- `clk`  in  1  Single clock; all logic is rising-edge.
- `rst`  in  1  Asynchronous, active-high reset.
- `CELV`  in  1  Supply pin; no logic function.
- `CELG`  in  1  Ground pin; no logic function.
- `SUB`  in  1  Substrate pin; no logic function.
- `pulse`  in  1  Asynchronous pulse from the generator.
- `arm`  in  1  Single-cycle strobe that starts capture. Honoured only in IDLE.
- `clear`  in  1  Synchronous clear to IDLE. Zeroes `count`, `ovf` and `drop`.
- `rd_ack`  in  1  Consumes the current result. Honoured only while `res_valid`=1.
- `width`  out  CNT_W  Latched width of the last completed pulse.
- `count`  out  NUM_W  Number of completed pulses since reset or clear.
- `res_valid`  out  1  `width` holds an unconsumed result.
- `ovf`  out  1  Sticky flag: a width measurement saturated.
- `drop`  out  1  Sticky flag: a rising edge arrived while in REPORT.
- `busy`  out  1  High in ARMED, HIGH and REPORT.

## Operation
- **Synchronizer.** `pulse` passes through a SYNC_STAGES flop chain to produce `ps`. A delay flop produces `ps_d`.
  - rise = `ps` & ~`ps_d`
  - fall = ~`ps` & `ps_d`
- **FSM states.** IDLE, ARMED, HIGH, REPORT.
  - IDLE: `arm` → ARMED. Pulses are ignored.
  - ARMED: rise → HIGH, with the width counter loaded to 1.
  - HIGH: while `ps`=1, the width counter increments each cycle. It saturates at 2^CNT_W−1, and saturation sets `ovf`. On fall → REPORT: latch `width` from the counter, set `res_valid`, and increment `count`, saturating at 2^NUM_W−1.
  - REPORT: `rd_ack` clears `res_valid` → ARMED. A rise seen in REPORT sets `drop`; that pulse is not measured.
- **Return to ARMED with `pulse` still high.** No rise is seen until `pulse` goes low and then high again, so no partial measurement is taken.
- **Priority.** `rst` > `clear` > FSM transitions.
  - `clear` in any state → IDLE.
  - `clear` zeroes `count`, `ovf`, `drop` and `res_valid`.
  - `clear` does not zero `width`, which holds its last value.
- **Ignored inputs.** `arm` outside IDLE and `rd_ack` with `res_valid`=0 have no effect.
- **Width rule.** A pulse sampled high on N consecutive `clk` edges gives `width` = min(N, 2^CNT_W−1).

## Timing
- **Reset.**
  - All outputs are 0.
  - The FSM is in IDLE.
  - The synchronizer flops and `ps_d` are 0.
- **Reset mid-pulse.** Any measurement in progress is discarded and none of its results survive.
- **`arm` latency.** `arm` sampled on edge k puts the FSM in ARMED after edge k, so `busy` is 1 from edge k.
- **Detection latency.** Counting the first edge that samples a new `pulse` level as edge 1:
  - the FSM reacts on edge SYNC_STAGES+1;
  - `res_valid` rises after edge SYNC_STAGES+1, i.e. edge 3 by default, following the first edge that samples `pulse` low.
- **Output stability.** `width` and `count` update on the same edge that sets `res_valid`. They are stable while `res_valid`=1.
- **`rd_ack`.**
  - `rd_ack` sampled on edge k clears `res_valid` after edge k; the FSM is in ARMED from that edge.
  - A rise evaluated on the next edge is measured.
- **Minimum pulse.** `pulse` must be high for at least 2 `clk` periods to be guaranteed detected; narrower pulses may be missed.
- **Minimum gap.** The low time between pulses must be at least 2 `clk` periods.

## Test plan
- **Basic measurement.** Reset, `arm`, then `pulse` high for 5 cycles. Expect `width`=5, `count`=1, and `res_valid` rising 3 edges after the first low sample. Then `rd_ack` → `res_valid`=0, `busy`=1.
- **Width saturation.** With CNT_W=8, hold `pulse` high for 300 cycles. Expect `width`=255 and `ovf`=1. `ovf` stays 1 through `rd_ack` and clears only on `clear`.
- **Dropped pulse.** Complete one pulse and withhold `rd_ack`. Send a 4-cycle pulse. Expect `drop`=1, `count`=1, and `width` unchanged. After `rd_ack`, a 3-cycle pulse gives `width`=3, `count`=2.
- **Clear mid-pulse.** Assert `clear` during HIGH. Expect IDLE, `busy`=0, and `count`, `ovf`, `drop` all 0. The subsequent falling edge produces no `res_valid`.
- **Async reset mid-measurement.** Assert `rst` mid-pulse, asynchronously to `clk`. Expect all outputs 0 immediately. After release, a pulse without `arm` is ignored.
- **Count saturation.** With NUM_W=4, send 20 armed and acked pulses. Expect `count`=15, with `res_valid` still set for every pulse.
